// File: rtl/n1_div_pkg.sv
// Shared types and constants for the 8-bit by 4-bit restoring divider.
// Optional build macro: N1_DIV_EARLY_EXIT_EN (see n1_div_8x4.sv).
package n1_div_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int CNT_W      = 4;

    // Eight BUSY cycles: the counter walks 7 down to 0.
    localparam logic [CNT_W-1:0]      LAST_STEP     = 4'd7;
    localparam logic [DIVIDEND_W-1:0] DIV_ZERO_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/n1_div_step.sv
// One combinational restoring-division step: shift in one dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module n1_div_step
    import n1_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] partial_rem,
    input  logic                 dividend_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] next_rem,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] trial;
    logic               unused_hi;

    assign shifted = {partial_rem, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});

    // partial_rem < divisor always holds, so both candidates fit in 4 bits.
    assign next_rem  = q_bit ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
    assign unused_hi = trial[DIVISOR_W] ^ shifted[DIVISOR_W];

endmodule

// File: rtl/n1_div_8x4.sv
// Unsigned 8-bit / 4-bit restoring divider, one quotient bit per BUSY cycle.
// Define N1_DIV_EARLY_EXIT_EN to bypass BUSY when dividend < divisor.
module n1_div_8x4
    import n1_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    state_e                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
    logic [DIVISOR_W-1:0]  divisor_q,  divisor_d;
    logic [DIVIDEND_W-1:0] quot_q,     quot_d;
    logic [DIVISOR_W-1:0]  rem_q,      rem_d;
    logic                  dz_q,       dz_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q_bit;
    logic                  accept;
    logic                  early;

    n1_div_step u_step (
        .partial_rem  (rem_q),
        .dividend_bit (dividend_q[DIVIDEND_W-1]),
        .divisor      (divisor_q),
        .next_rem     (step_rem),
        .q_bit        (step_q_bit)
    );

    assign accept = in_valid && (state_q == IDLE);

`ifdef N1_DIV_EARLY_EXIT_EN
    assign early = (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor});
`else
    assign early = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dividend_d = dividend;
                    divisor_d  = divisor;
                    dz_d       = 1'b0;
                    cnt_d      = '0;
                    if (divisor == '0) begin
                        quot_d  = DIV_ZERO_QUOT;
                        rem_d   = dividend[DIVISOR_W-1:0];
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (early) begin
                        quot_d  = '0;
                        rem_d   = dividend[DIVISOR_W-1:0];
                        state_d = DONE;
                    end else begin
                        quot_d  = '0;
                        rem_d   = '0;
                        cnt_d   = LAST_STEP;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // The dividend register shifts left so its MSB always feeds the step.
                dividend_d = {dividend_q[DIVIDEND_W-2:0], 1'b0};
                quot_d     = {quot_q[DIVIDEND_W-2:0], step_q_bit};
                rem_d      = step_rem;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/n1_div_8x4.md
N1_DIV_8X4 -- requirements
Module: n1_div_8x4

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 8-bit dividend, 4-bit divisor, 8-bit quotient and 4-bit remainder.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 dividend  input  8  unsigned dividend, sampled on the accept edge.
REQ-007 divisor  input  4  unsigned divisor, sampled on the accept edge.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 quotient  output  8  unsigned quotient.
REQ-011 remainder  output  4  unsigned remainder.
REQ-012 div_zero  output  1  result came from a zero divisor.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an operand pair is accepted on the edge where in_valid && in_ready.
REQ-015 On accept with divisor != 0, the block SHALL enter BUSY, load a 4-bit step counter with 7, clear the partial remainder and register the operands.
REQ-016 Each BUSY cycle SHALL perform one restoring step, MSB first:
- trial = {partial_rem, next dividend bit} minus divisor, computed 5 bits wide;
- if trial is non-negative: quotient bit = 1 and partial_rem = trial[3:0];
- otherwise: quotient bit = 0 and partial_rem keeps the shifted value.
REQ-017 BUSY SHALL last exactly 8 cycles; when the counter reaches 0 the block SHALL enter DONE, so out_valid rises on the 8th edge after accept.
REQ-018 In DONE, out_valid SHALL be 1 and quotient, remainder and div_zero SHALL stay stable until the edge where out_valid && out_ready; that edge returns the block to IDLE.
REQ-019 in_ready SHALL be 0 during DONE, so a new accept cannot occur on the same edge as the result handshake.
REQ-020 A divisor of 0 SHALL skip BUSY and go straight to DONE on the next edge, with quotient = 8'hFF, remainder = dividend[3:0] and div_zero = 1.
REQ-021 div_zero SHALL be 0 for every non-zero divisor.
REQ-022 For a non-zero divisor, quotient*divisor + remainder SHALL equal dividend exactly, with remainder < divisor.
REQ-023 in_valid, dividend and divisor SHALL be ignored outside IDLE.

Reset
REQ-024 While rst_n = 0 at a clock edge, the block SHALL enter IDLE with in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_zero = 0 and step counter = 0.
REQ-025 Reset asserted in BUSY or DONE SHALL abort the operation without producing a result; the first accept after reset SHALL be processed normally.

Configuration
REQ-026 The macro N1_DIV_EARLY_EXIT_EN SHALL control early exit.
REQ-027 With N1_DIV_EARLY_EXIT_EN defined, an accepted pair with divisor != 0 and dividend < divisor SHALL skip BUSY and go to DONE on the next edge with quotient = 0 and remainder = dividend[3:0].
REQ-028 Without N1_DIV_EARLY_EXIT_EN, such a pair SHALL take the full 8-cycle BUSY path; the result values SHALL be identical in both builds.

Structure
REQ-029 A shared package n1_div_pkg SHALL hold:
- the state enum (IDLE, BUSY, DONE);
- width constants (8, 4);
- the divide-by-zero quotient constant 8'hFF.
REQ-030 The combinational restoring step SHALL be a sub-module n1_div_step:
- inputs: partial_rem[3:0], dividend bit, divisor[3:0];
- outputs: next_rem[3:0], q_bit.
REQ-031 The top module SHALL contain only the FSM, the counter and the operand, quotient and remainder registers.

Verification
REQ-032 200 / 7 -> out_valid 8 cycles after accept, quotient = 28, remainder = 4, div_zero = 0.
REQ-033 255 / 1, then 255 / 15 -> quotient = 255, remainder = 0; then quotient = 17, remainder = 0; in_ready = 0 throughout each BUSY and DONE.
REQ-034 13 / 0 -> out_valid 1 cycle after accept, quotient = 8'hFF, remainder = 4'hD, div_zero = 1.
REQ-035 3 / 9 -> quotient = 0, remainder = 3; latency 1 cycle with N1_DIV_EARLY_EXIT_EN, 8 cycles without it.
REQ-036 100 / 6 with out_ready held 0 for 5 cycles -> out_valid and quotient = 16, remainder = 4 stay stable; return to IDLE only on the out_ready edge.
REQ-037 rst_n = 0 for one cycle in the 4th BUSY cycle -> all outputs at reset values, no out_valid pulse; a following 50 / 5 -> quotient = 10, remainder = 0.
